// File: rtl/mips_pc_pkg.sv
// Shared constants and type definitions for the fetch-PC redirect logic.
package mips_pc_pkg;

    localparam int unsigned NBITS_DEFAULT     = 32;
    localparam int unsigned NBITSJUMP_DEFAULT = 26;
    localparam int unsigned PC_INCR           = 4;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StWait   = 2'd1,
        StHalted = 2'd2
    } pc_state_e;

    // Winning redirect source after priority resolution.
    typedef enum logic [1:0] {
        RedirNone   = 2'd0,
        RedirJump   = 2'd1,
        RedirJr     = 2'd2,
        RedirBranch = 2'd3
    } redir_src_e;

endpackage

// File: rtl/pc_jump_redirect_if.sv
// Bundle of decode/execute redirect inputs and fetch-side outputs of the PC unit.
interface pc_jump_redirect_if
    import mips_pc_pkg::*;
#(
    parameter int unsigned NBITS     = NBITS_DEFAULT,
    parameter int unsigned NBITSJUMP = NBITSJUMP_DEFAULT
);

    logic                 i_id_jump;
    logic [NBITSJUMP-1:0] i_id_instr_index;
    logic [NBITS-1:0]     i_id_pc4;
    logic                 i_id_jr;
    logic [NBITS-1:0]     i_id_jr_target;
    logic                 i_ex_branch_taken;
    logic [NBITS-1:0]     i_ex_branch_target;
    logic                 i_stall;
    logic                 i_halt;
    logic                 i_imem_ready;
    logic [NBITS-1:0]     o_pc;
    logic [NBITS-1:0]     o_pc4;
    logic                 o_imem_req;
    logic                 o_flush_if_id;
    logic                 o_flush_id_ex;
    logic                 o_halted;

    modport master (
        output i_id_jump, i_id_instr_index, i_id_pc4, i_id_jr, i_id_jr_target,
               i_ex_branch_taken, i_ex_branch_target, i_stall, i_halt, i_imem_ready,
        input  o_pc, o_pc4, o_imem_req, o_flush_if_id, o_flush_id_ex, o_halted
    );

    modport slave (
        input  i_id_jump, i_id_instr_index, i_id_pc4, i_id_jr, i_id_jr_target,
               i_ex_branch_taken, i_ex_branch_target, i_stall, i_halt, i_imem_ready,
        output o_pc, o_pc4, o_imem_req, o_flush_if_id, o_flush_id_ex, o_halted
    );

endinterface

// File: rtl/pc_jump_target.sv
// J/JAL target: upper PC+4 region bits, instr_index, then word alignment.
module pc_jump_target
    import mips_pc_pkg::*;
#(
    parameter int unsigned NBITS     = NBITS_DEFAULT,
    parameter int unsigned NBITSJUMP = NBITSJUMP_DEFAULT
) (
    input  logic [NBITS-NBITSJUMP-3:0] pc4_hi_i,
    input  logic [NBITSJUMP-1:0]       instr_index_i,
    output logic [NBITS-1:0]           target_o
);

    assign target_o = {pc4_hi_i, instr_index_i, 2'b00};

endmodule

// File: rtl/pc_jump_redirect.sv
// Fetch PC register with prioritised branch/jump redirect, one-entry pending
// target for stalled redirects, and a terminal halt state.
module pc_jump_redirect
    import mips_pc_pkg::*;
#(
    parameter int unsigned      NBITS     = NBITS_DEFAULT,
    parameter int unsigned      NBITSJUMP = NBITSJUMP_DEFAULT,
    parameter logic [NBITS-1:0] RESET_PC  = NBITS'(RESET_PC_DEFAULT)
) (
    input logic               i_clk,
    input logic               i_rst_n,
    pc_jump_redirect_if.slave bus
);

    localparam int unsigned JumpHiW = NBITS - NBITSJUMP - 2;

    pc_state_e        state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [NBITS-1:0] pend_q, pend_d;
    logic [NBITS-1:0] pc4;
    logic [NBITS-1:0] jump_target;
    logic [NBITS-1:0] redir_target;
    redir_src_e       redir_src;
    logic             redir_valid;
    logic             fetch_go;

    assign pc4      = pc_q + NBITS'(PC_INCR);
    assign fetch_go = bus.i_imem_ready & ~bus.i_stall;

    pc_jump_target #(
        .NBITS     (NBITS),
        .NBITSJUMP (NBITSJUMP)
    ) u_jump_target (
        .pc4_hi_i      (bus.i_id_pc4[NBITS-1 -: JumpHiW]),
        .instr_index_i (bus.i_id_instr_index),
        .target_o      (jump_target)
    );

    // EX branch beats everything; ID-stage redirects only count in RUN and lose to halt.
    always_comb begin
        redir_src    = RedirNone;
        redir_target = bus.i_ex_branch_target;
        if (state_q != StHalted && bus.i_ex_branch_taken) begin
            redir_src = RedirBranch;
        end else if (state_q == StRun && !bus.i_halt) begin
            if (bus.i_id_jr) begin
                redir_src    = RedirJr;
                redir_target = bus.i_id_jr_target;
            end else if (bus.i_id_jump) begin
                redir_src    = RedirJump;
                redir_target = jump_target;
            end
        end
    end

    assign redir_valid = (redir_src != RedirNone);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        unique case (state_q)
            StRun: begin
                if (redir_valid) begin
                    if (fetch_go) begin
                        pc_d = redir_target;
                    end else begin
                        pend_d  = redir_target;
                        state_d = StWait;
                    end
                end else if (bus.i_halt) begin
                    state_d = StHalted;
                end else if (fetch_go) begin
                    pc_d = pc4;
                end
            end
            StWait: begin
                // Only a younger EX branch can reach here; it replaces the pending target.
                if (redir_valid) begin
                    pend_d = redir_target;
                end
                if (fetch_go) begin
                    pc_d    = redir_valid ? redir_target : pend_q;
                    state_d = StRun;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    always_comb begin
        bus.o_imem_req    = 1'b0;
        bus.o_flush_if_id = 1'b0;
        bus.o_flush_id_ex = 1'b0;
        bus.o_halted      = 1'b0;
        if (i_rst_n) begin
            bus.o_imem_req    = (state_q != StHalted);
            bus.o_flush_if_id = redir_valid;
            bus.o_flush_id_ex = (redir_src == RedirBranch);
            bus.o_halted      = (state_q == StHalted);
        end
    end

    assign bus.o_pc  = pc_q;
    assign bus.o_pc4 = pc4;

endmodule

// File: doc/pc_jump_redirect.md
PC_JUMP_REDIRECT -- requirements
Module: pc_jump_redirect

Interface
REQ-001 SHALL have parameter NBITS, default 32, meaning PC/address width.
REQ-002 SHALL have parameter NBITSJUMP, default 26, meaning J-type instr_index width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value after reset.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_id_jump  input  1  J/JAL decoded in ID.
REQ-007 SHALL have port i_id_instr_index  input  NBITSJUMP  instr_index of J/JAL in ID.
REQ-008 SHALL have port i_id_pc4  input  NBITS  PC+4 of instruction in ID.
REQ-009 SHALL have port i_id_jr  input  1  JR/JALR decoded in ID.
REQ-010 SHALL have port i_id_jr_target  input  NBITS  register-sourced jump target.
REQ-011 SHALL have port i_ex_branch_taken  input  1  branch resolved taken in EX.
REQ-012 SHALL have port i_ex_branch_target  input  NBITS  branch target from EX.
REQ-013 SHALL have port i_stall  input  1  hazard-unit fetch stall.
REQ-014 SHALL have port i_halt  input  1  HALT decoded in ID.
REQ-015 SHALL have port i_imem_ready  input  1  instruction memory accepts o_pc this cycle.
REQ-016 SHALL have port o_pc  output  NBITS  current fetch address.
REQ-017 SHALL have port o_pc4  output  NBITS  o_pc + 4.
REQ-018 SHALL have port o_imem_req  output  1  fetch request valid.
REQ-019 SHALL have port o_flush_if_id  output  1  kill instruction in IF/ID.
REQ-020 SHALL have port o_flush_id_ex  output  1  kill instruction in ID/EX.
REQ-021 SHALL have port o_halted  output  1  fetch permanently stopped.

Function
REQ-022 SHALL compute J target as {i_id_pc4[31:28], i_id_instr_index, 2'b00}; all PC arithmetic modulo 2^NBITS (0xFFFF_FFFC+4 wraps to 0).
REQ-023 SHALL implement states RUN, WAIT, HALTED; o_imem_req = 1 in RUN and WAIT, 0 in HALTED and in reset.
REQ-024 SHALL advance PC (o_pc <= o_pc4) in RUN only on edges with i_stall=0 and i_imem_ready=1; otherwise hold o_pc stable.
REQ-025 SHALL apply redirect priority: EX branch > ID JR > ID J; EX branch in same cycle discards any ID jump/JR/halt.
REQ-026 SHALL load the selected target into o_pc at the sampling edge when i_stall=0 and i_imem_ready=1 (latency 1 edge).
REQ-027 SHALL otherwise latch the target into a one-entry pending buffer and go RUN->WAIT; WAIT->RUN loads pending target at first edge with i_stall=0 and i_imem_ready=1.
REQ-028 SHALL, in WAIT, overwrite the pending target with a new EX branch; SHALL ignore ID jump/JR/halt (wrong path).
REQ-029 SHALL assert o_flush_if_id combinationally in any cycle a redirect is accepted (RUN or WAIT overwrite); o_flush_id_ex only for EX branch.
REQ-030 SHALL go RUN->HALTED on i_halt with no EX branch taken; HALTED holds o_pc, ignores all inputs, exits only by reset.

Reset
REQ-031 SHALL on i_rst_n=0 immediately force o_pc=RESET_PC, pending buffer invalid, state RUN, o_imem_req=0, both flushes 0, o_halted=0.
REQ-032 SHALL abandon any pending redirect when reset asserts mid-WAIT; first fetch after release is RESET_PC.

Structure
REQ-033 SHALL place state encoding, RESET_PC default and width constants in shared package mips_pc_pkg.
REQ-034 SHALL instantiate one combinational sub-module pc_jump_target for REQ-022; FSM and PC register stay in the top.

Verification
REQ-035 Reset release, ready=1, stall=0 -> o_pc sequence 0x0,0x4,0x8; o_imem_req=1 from first cycle after release.
REQ-036 i_id_jump=1, i_id_pc4=0x1000_0010, index=0x0000040 -> next o_pc=0x1000_0100, o_flush_if_id=1 one cycle, o_flush_id_ex=0.
REQ-037 Same cycle i_ex_branch_taken=1 target 0x200 and i_id_jr=1 target 0x300 -> o_pc=0x200, both flushes 1.
REQ-038 J to 0x400 while i_stall=1 for 3 cycles -> o_pc held, state WAIT; o_pc=0x400 on edge after stall drops.
REQ-039 i_imem_ready=0 with pending branch 0x500, then new EX branch 0x600 -> o_pc=0x600 once ready=1.
REQ-040 i_halt=1 at o_pc=0x20 -> o_halted=1, o_imem_req=0, o_pc frozen; reset mid-WAIT -> o_pc=RESET_PC.
